// File: rtl/fc_link_arbiter.sv
// fc_link_arbiter: decides which controller owns the shared FC bus link.
// The read controller fetches data, weights and bias. The write controller
// stores results. Ownership is granted for a whole burst, meaning the address
// phase plus the data phase. Priority is round-robin between the two sides.
// Every change of owner passes through a gap with both links low. A watchdog
// releases a burst that stops making progress on the bus.
module fc_link_arbiter #(
  parameter int TURN_CYCLES = 1,
  parameter int TIMEOUT     = 256,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rd_req,
  input  logic             i_wr_req,
  output logic             o_link_read,
  output logic             o_link_write,
  input  logic             i_arvalid,
  input  logic             i_arready,
  input  logic             i_rvalid,
  input  logic             i_rlast,
  input  logic             i_awvalid,
  input  logic             i_awready,
  input  logic             i_wready,
  input  logic             i_wuser_last,
  output logic             o_busy,
  output logic             o_timeout_err,
  output logic [CNT_W-1:0] o_rd_bursts,
  output logic [CNT_W-1:0] o_wr_bursts
);

  // Arbiter states. A plain encoding keeps the output decode simple.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_ADDR = 3'd3;
  localparam logic [2:0] S_WR_DATA = 3'd4;
  localparam logic [2:0] S_TURN    = 3'd5;

  // The watchdog counter never needs to hold more than TIMEOUT-1.
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int WD_TERM_I = TIMEOUT - 1;
  localparam logic [WD_W-1:0] WD_TERM = WD_TERM_I[WD_W-1:0];

  // The turnaround counter is loaded with TURN_CYCLES-1. When the gap is
  // zero the counter is never used, but it keeps a legal one-bit width.
  localparam int TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  localparam int TURN_LOAD_I = (TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0;
  localparam logic [TURN_W-1:0] TURN_LOAD = TURN_LOAD_I[TURN_W-1:0];
  localparam logic [2:0] S_RELEASE = (TURN_CYCLES > 0) ? S_TURN : S_IDLE;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic              r_last_wr;
  logic [TURN_W-1:0] r_turn_cnt;
  logic [TURN_W-1:0] w_turn_next;
  logic [WD_W-1:0]   r_wd_cnt;
  logic [WD_W-1:0]   w_wd_next;
  logic              r_timeout_err;
  logic [CNT_W-1:0]  r_rd_bursts;
  logic [CNT_W-1:0]  r_wr_bursts;

  logic w_wd_term;
  logic w_release;
  logic w_release_wr;
  logic w_timeout;
  logic w_rd_done;
  logic w_wr_done;
  logic w_ar_hs;
  logic w_aw_hs;
  logic w_rd_last;
  logic w_wr_last;
  logic w_grant_rd;

  // Handshake decode. These signals only take effect in the owner's states.
  assign w_ar_hs   = i_arvalid & i_arready;
  assign w_aw_hs   = i_awvalid & i_awready;
  assign w_rd_last = i_rvalid & i_rlast;
  assign w_wr_last = i_wready & i_wuser_last;
  assign w_wd_term = (r_wd_cnt == WD_TERM);

  // Round-robin choice. With both requests present, read wins when the last
  // owner was the writer.
  assign w_grant_rd = i_rd_req & (~i_wr_req | r_last_wr);

  // Next-state, watchdog and turnaround logic. In every owning state a
  // progress event or a completion is checked before the watchdog terminal
  // count, so a handshake on the last cycle always wins over a timeout.
  always_comb begin
    w_next_state = r_state;
    w_turn_next  = r_turn_cnt;
    w_wd_next    = '0;
    w_release    = 1'b0;
    w_release_wr = 1'b0;
    w_timeout    = 1'b0;
    w_rd_done    = 1'b0;
    w_wr_done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_rd) begin
          w_next_state = S_RD_ADDR;
        end else if (i_wr_req) begin
          w_next_state = S_WR_ADDR;
        end
      end
      S_RD_ADDR: begin
        if (w_ar_hs) begin
          w_next_state = S_RD_DATA;
        end else if (!i_rd_req) begin
          w_release = 1'b1;
        end else if (w_wd_term) begin
          w_release = 1'b1;
          w_timeout = 1'b1;
        end else begin
          w_wd_next = r_wd_cnt + 1'b1;
        end
      end
      S_RD_DATA: begin
        if (w_rd_last) begin
          w_release = 1'b1;
          w_rd_done = 1'b1;
        end else if (i_rvalid) begin
          w_wd_next = '0;
        end else if (w_wd_term) begin
          w_release = 1'b1;
          w_timeout = 1'b1;
        end else begin
          w_wd_next = r_wd_cnt + 1'b1;
        end
      end
      S_WR_ADDR: begin
        w_release_wr = 1'b1;
        if (w_aw_hs) begin
          w_next_state = S_WR_DATA;
        end else if (!i_wr_req) begin
          w_release = 1'b1;
        end else if (w_wd_term) begin
          w_release = 1'b1;
          w_timeout = 1'b1;
        end else begin
          w_wd_next = r_wd_cnt + 1'b1;
        end
      end
      S_WR_DATA: begin
        w_release_wr = 1'b1;
        if (w_wr_last) begin
          w_release = 1'b1;
          w_wr_done = 1'b1;
        end else if (i_wready) begin
          w_wd_next = '0;
        end else if (w_wd_term) begin
          w_release = 1'b1;
          w_timeout = 1'b1;
        end else begin
          w_wd_next = r_wd_cnt + 1'b1;
        end
      end
      S_TURN: begin
        if (r_turn_cnt == '0) begin
          w_next_state = S_IDLE;
        end else begin
          w_turn_next = r_turn_cnt - 1'b1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    if (w_release) begin
      w_next_state = S_RELEASE;
      w_turn_next  = TURN_LOAD;
      w_wd_next    = '0;
    end
  end

  // State, turnaround, watchdog, round-robin pointer and timeout pulse registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_turn_cnt    <= '0;
      r_wd_cnt      <= '0;
      r_last_wr     <= 1'b1;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_turn_cnt    <= w_turn_next;
      r_wd_cnt      <= w_wd_next;
      r_timeout_err <= w_timeout;
      if (w_release) begin
        r_last_wr <= w_release_wr;
      end
    end
  end

  // Saturating completed-burst counters. Timeouts and abandoned bursts never reach here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_bursts <= '0;
      r_wr_bursts <= '0;
    end else begin
      if (w_rd_done && (r_rd_bursts != CNT_MAX)) begin
        r_rd_bursts <= r_rd_bursts + 1'b1;
      end
      if (w_wr_done && (r_wr_bursts != CNT_MAX)) begin
        r_wr_bursts <= r_wr_bursts + 1'b1;
      end
    end
  end

  // Moore outputs decoded from the registered state. Reset clears the state
  // asynchronously, so both links drop within the cycle that reset is asserted.
  assign o_link_read   = (r_state == S_RD_ADDR) || (r_state == S_RD_DATA);
  assign o_link_write  = (r_state == S_WR_ADDR) || (r_state == S_WR_DATA);
  assign o_busy        = (r_state != S_IDLE);
  assign o_timeout_err = r_timeout_err;
  assign o_rd_bursts   = r_rd_bursts;
  assign o_wr_bursts   = r_wr_bursts;

endmodule

// File: tb/tb_fc_link_arbiter.sv
// tb_fc_link_arbiter: directed bench for the FC bus link arbiter.
// Expected grant owners go into a queue as requests are driven. A monitor
// pops one entry each time a link rises and compares it with the new owner.
module tb_fc_link_arbiter;

  logic clk;
  logic rst;
  logic rdReq;
  logic wrReq;
  logic linkRead;
  logic linkWrite;
  logic arValid;
  logic arReady;
  logic rValid;
  logic rLast;
  logic awValid;
  logic awReady;
  logic wReady;
  logic wUserLast;
  logic busy;
  logic timeoutErr;
  logic [15:0] rdBursts;
  logic [15:0] wrBursts;

  int checks = 0;
  int errors = 0;
  int pulseCount = 0;
  logic sbQ[$];
  logic prevRead = 1'b0;
  logic prevWrite = 1'b0;
  logic expOwner;

  fc_link_arbiter #(
    .TURN_CYCLES(1),
    .TIMEOUT(256),
    .CNT_W(16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_rd_req(rdReq),
    .i_wr_req(wrReq),
    .o_link_read(linkRead),
    .o_link_write(linkWrite),
    .i_arvalid(arValid),
    .i_arready(arReady),
    .i_rvalid(rValid),
    .i_rlast(rLast),
    .i_awvalid(awValid),
    .i_awready(awReady),
    .i_wready(wReady),
    .i_wuser_last(wUserLast),
    .o_busy(busy),
    .o_timeout_err(timeoutErr),
    .o_rd_bursts(rdBursts),
    .o_wr_bursts(wrBursts)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr);
    rdReq = rd;
    wrReq = wr;
  endtask

  task automatic waitGrant(input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      if (linkRead || linkWrite) break;
      tick();
    end
    checkOutput("grant_wait", 32'(linkRead | linkWrite), 32'd1);
  endtask

  task automatic doRead();
    arValid = 1'b1; arReady = 1'b1;
    tick();
    arValid = 1'b0; arReady = 1'b0;
    rValid = 1'b1; rLast = 1'b1;
    tick();
    rValid = 1'b0; rLast = 1'b0;
  endtask

  task automatic doWrite();
    awValid = 1'b1; awReady = 1'b1;
    tick();
    awValid = 1'b0; awReady = 1'b0;
    wReady = 1'b1; wUserLast = 1'b1;
    tick();
    wReady = 1'b0; wUserLast = 1'b0;
  endtask

  // Grant scoreboard, link exclusivity and timeout pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    checks++;
    assert ((linkRead & linkWrite) === 1'b0) else begin
      errors++;
      $error("[TB] FAIL exclusive observed=%b%b expected=not both", linkRead, linkWrite);
    end
    if (timeoutErr === 1'b1) pulseCount++;
    if ((linkRead && !prevRead) || (linkWrite && !prevWrite)) begin
      checks++;
      if (sbQ.size() == 0) begin
        errors++;
        $error("[TB] FAIL grant_unexpected observed rd=%b wr=%b expected none", linkRead, linkWrite);
      end else begin
        expOwner = sbQ.pop_front();
        assert (linkWrite === expOwner && linkRead === !expOwner) else begin
          errors++;
          $error("[TB] FAIL grant_owner observed wr=%b rd=%b expected wr=%b", linkWrite, linkRead, expOwner);
        end
      end
    end
    prevRead = linkRead;
    prevWrite = linkWrite;
  end

  // Directed sequence.
  initial begin
    rst = 1'b1;
    rdReq = 0; wrReq = 0;
    arValid = 0; arReady = 0; rValid = 0; rLast = 0;
    awValid = 0; awReady = 0; wReady = 0; wUserLast = 0;
    tick();
    tick();
    checkOutput("rst_link_read", 32'(linkRead), 32'd0);
    checkOutput("rst_link_write", 32'(linkWrite), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_timeout", 32'(timeoutErr), 32'd0);
    checkOutput("rst_rd_bursts", 32'(rdBursts), 32'd0);
    checkOutput("rst_wr_bursts", 32'(wrBursts), 32'd0);
    rst = 1'b0;
    tick();

    // Read request, one-cycle grant latency, then a four-beat read burst.
    applyStimulus(1'b1, 1'b0);
    sbQ.push_back(1'b0);
    checkOutput("t1_pre_grant", 32'(linkRead), 32'd0);
    tick();
    checkOutput("t1_grant", 32'(linkRead), 32'd1);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    // Write-side handshakes while read owns the link must be ignored.
    awValid = 1; awReady = 1; wReady = 1; wUserLast = 1;
    tick();
    awValid = 0; awReady = 0; wReady = 0; wUserLast = 0;
    checkOutput("t1_ignore_link", 32'(linkRead), 32'd1);
    checkOutput("t1_ignore_wr_bursts", 32'(wrBursts), 32'd0);
    arValid = 1; arReady = 1;
    tick();
    arValid = 0; arReady = 0;
    checkOutput("t1_data_phase", 32'(linkRead), 32'd1);
    for (int i = 0; i < 4; i++) begin
      rValid = 1'b1;
      rLast = (i == 3);
      if (i == 3) begin
        applyStimulus(1'b0, 1'b1);
        sbQ.push_back(1'b1);
      end
      tick();
    end
    rValid = 0; rLast = 0;
    checkOutput("t1_release", 32'(linkRead), 32'd0);
    checkOutput("t1_rd_bursts", 32'(rdBursts), 32'd1);
    checkOutput("t1_gap0", 32'(linkWrite), 32'd0);
    tick();
    checkOutput("t1_gap1", 32'(linkWrite), 32'd0);
    tick();
    checkOutput("t1_wr_grant", 32'(linkWrite), 32'd1);
    doWrite();
    applyStimulus(1'b0, 1'b0);
    checkOutput("t1_wr_bursts", 32'(wrBursts), 32'd1);
    checkOutput("t1_wr_release", 32'(linkWrite), 32'd0);

    // Both requests held: grants must alternate read, write, read, write.
    applyStimulus(1'b1, 1'b1);
    sbQ.push_back(1'b0); sbQ.push_back(1'b1);
    sbQ.push_back(1'b0); sbQ.push_back(1'b1);
    for (int b = 0; b < 4; b++) begin
      waitGrant(10);
      if (linkRead) doRead();
      else if (linkWrite) doWrite();
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("t2_rd_bursts", 32'(rdBursts), 32'd3);
    checkOutput("t2_wr_bursts", 32'(wrBursts), 32'd3);

    // Write burst stalls in the data phase until the watchdog fires.
    applyStimulus(1'b0, 1'b1);
    sbQ.push_back(1'b1);
    waitGrant(10);
    awValid = 1; awReady = 1;
    tick();
    awValid = 0; awReady = 0;
    repeat (255) tick();
    checkOutput("t3_pre_term_link", 32'(linkWrite), 32'd1);
    checkOutput("t3_pre_term_err", 32'(timeoutErr), 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0);
    checkOutput("t3_timeout_err", 32'(timeoutErr), 32'd1);
    checkOutput("t3_link_drop", 32'(linkWrite), 32'd0);
    checkOutput("t3_wr_bursts", 32'(wrBursts), 32'd3);
    tick();
    checkOutput("t3_err_pulse_end", 32'(timeoutErr), 32'd0);
    checkOutput("t3_pulse_count", 32'(pulseCount), 32'd1);

    // Same stall, but the last write beat lands on the terminal cycle.
    applyStimulus(1'b0, 1'b1);
    sbQ.push_back(1'b1);
    waitGrant(10);
    awValid = 1; awReady = 1;
    tick();
    awValid = 0; awReady = 0;
    repeat (255) tick();
    wReady = 1; wUserLast = 1;
    tick();
    wReady = 0; wUserLast = 0;
    applyStimulus(1'b0, 1'b0);
    checkOutput("t4_no_timeout", 32'(timeoutErr), 32'd0);
    checkOutput("t4_link_drop", 32'(linkWrite), 32'd0);
    checkOutput("t4_wr_bursts", 32'(wrBursts), 32'd4);
    tick();
    checkOutput("t4_pulse_count", 32'(pulseCount), 32'd1);

    // Read request withdrawn before the address handshake; pending write follows.
    applyStimulus(1'b1, 1'b1);
    sbQ.push_back(1'b0); sbQ.push_back(1'b1);
    waitGrant(10);
    checkOutput("t5_rd_grant", 32'(linkRead), 32'd1);
    applyStimulus(1'b0, 1'b1);
    tick();
    checkOutput("t5_abandon", 32'(linkRead), 32'd0);
    checkOutput("t5_busy_turn", 32'(busy), 32'd1);
    checkOutput("t5_rd_bursts", 32'(rdBursts), 32'd3);
    checkOutput("t5_no_timeout", 32'(timeoutErr), 32'd0);
    tick();
    checkOutput("t5_gap", 32'(linkWrite), 32'd0);
    tick();
    checkOutput("t5_wr_grant", 32'(linkWrite), 32'd1);
    doWrite();
    applyStimulus(1'b0, 1'b0);
    checkOutput("t5_wr_bursts", 32'(wrBursts), 32'd5);

    // Complete a read so read is last owner, then reset in the middle of another read.
    applyStimulus(1'b1, 1'b0);
    sbQ.push_back(1'b0);
    waitGrant(10);
    doRead();
    checkOutput("t6_rd_bursts", 32'(rdBursts), 32'd4);
    sbQ.push_back(1'b0);
    waitGrant(10);
    arValid = 1; arReady = 1;
    tick();
    arValid = 0; arReady = 0;
    rValid = 1;
    tick();
    rValid = 0;
    checkOutput("t6_mid_burst", 32'(linkRead), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_link", 32'(linkRead), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_rd_bursts", 32'(rdBursts), 32'd0);
    checkOutput("t6_rst_wr_bursts", 32'(wrBursts), 32'd0);
    applyStimulus(1'b0, 1'b0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1);
    sbQ.push_back(1'b0);
    tick();
    checkOutput("t6_post_rst_rd", 32'(linkRead), 32'd1);
    checkOutput("t6_post_rst_wr", 32'(linkWrite), 32'd0);
    applyStimulus(1'b1, 1'b0);
    doRead();
    applyStimulus(1'b0, 1'b0);
    checkOutput("t6_rd_bursts_after", 32'(rdBursts), 32'd1);
    tick();
    tick();
    tick();
    checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
    checkOutput("final_pulse_count", 32'(pulseCount), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
